one_to_four_distributor: RTL and testbench

//  Registered 1-to-4 data distributor: the inverse of the four-input data selector.
//  - One input word plus 2-bit select {E1,E0}; word is steered to output channel 0..3.
//  - Each channel has a 1-entry holding register and valid/ready handshake.
//  - Sits between a single producer and four consumers; pairs with the selector for loopback tests.

---
 rtl/one_to_four_distributor_if.sv | 25 ++
 rtl/one_to_four_distributor.sv | 80 ++++++++
 tb/tb_one_to_four_distributor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/one_to_four_distributor_if.sv
// Handshake bundle between one producer, the 1-to-4 distributor and its four consumers.
// master: producer/consumer side (drives din, select, in_valid, out_ready).
// slave:  distributor side (drives in_ready, out_data, out_valid).
interface one_to_four_distributor_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               E0;
  logic               E1;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;

  modport master (
    output din, E0, E1, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  din, E0, E1, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/one_to_four_distributor.sv
// Registered 1-to-4 data distributor with a 1-entry holding register per channel.
// Optional feature macro: DISTRIBUTOR_ROUND_ROBIN_EN
//   defined   -> E0/E1 ignored, a 2-bit round-robin pointer picks the target channel
//   undefined -> target channel is {E1,E0}
//
// Handshake: a word moves across an interface in any cycle where valid and ready
// are both high at the rising edge. in_ready depends only on the target channel's
// occupancy and its consumer's out_ready, never on in_valid. Once out_valid[n]
// is high, out_data[n]/out_valid[n] stay put until out_ready[n] is seen.
module one_to_four_distributor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  one_to_four_distributor_if.slave   bus,
  output logic [CNT_W-1:0]           xfer_cnt
);

  logic [1:0]         w_tgt;
  logic               w_in_ready;
  logic               w_accept;
  logic [3:0]         r_valid;
  logic [4*WIDTH-1:0] r_data;
  logic [CNT_W-1:0]   r_cnt;

`ifdef DISTRIBUTOR_ROUND_ROBIN_EN
  logic [1:0] r_rr_ptr;

  // Round-robin pointer: advances only on an accepted word, holds during stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= 2'd0;
    end else if (w_accept) begin
      r_rr_ptr <= r_rr_ptr + 2'd1;
    end
  end

  assign w_tgt = r_rr_ptr;
`else
  assign w_tgt = {bus.E1, bus.E0};
`endif

  // A word can enter when the target slot is empty or is being emptied this cycle.
  // No alternate channel is ever chosen when the target is blocked.
  assign w_in_ready = rst_n & (~r_valid[w_tgt] | bus.out_ready[w_tgt]);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Per-channel holding registers: load on accept (wins over drain), clear on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 4'd0;
      r_data  <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_accept && (w_tgt == 2'(n))) begin
          r_data[n*WIDTH +: WIDTH] <= bus.din;
          r_valid[n]               <= 1'b1;
        end else if (r_valid[n] && bus.out_ready[n]) begin
          r_valid[n]               <= 1'b0;
        end
      end
    end
  end

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign xfer_cnt      = r_cnt;

endmodule

// File: tb/tb_one_to_four_distributor.sv
// Self-checking bench for one_to_four_distributor: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_one_to_four_distributor;
  localparam int W     = 4;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [CNT_W-1:0] xfer_cnt;

  always #5 clk = ~clk;

  one_to_four_distributor_if #(.WIDTH(W)) bus ();

  one_to_four_distributor #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each channel is a one-word mailbox; exp_q holds words per channel in arrival order.
  logic [3:0]       m_valid;
  logic [W-1:0]     m_data [4];
  logic [CNT_W-1:0] m_cnt;
  int               m_ptr;
  logic [W-1:0]     exp_q [4][$];

  task automatic model_reset();
    m_valid = 4'd0;
    m_cnt   = '0;
    m_ptr   = 0;
    for (int n = 0; n < 4; n++) begin
      m_data[n] = '0;
      exp_q[n].delete();
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic rst, input logic iv, input logic [W-1:0] d,
                       input logic [1:0] sel, input logic [3:0] ordy);
    int   t;
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    rst_n         = rst;
    bus.in_valid  = iv;
    bus.din       = d;
    bus.E1        = sel[1];
    bus.E0        = sel[0];
    bus.out_ready = ordy;
    #1;
`ifdef DISTRIBUTOR_ROUND_ROBIN_EN
    t = m_ptr;
`else
    t = int'(sel);
`endif
    exp_rdy = rst & (~m_valid[t] | ordy[t]);
    acc     = iv & exp_rdy;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    check("out_valid", {28'd0, bus.out_valid}, {28'd0, m_valid});
    for (int n = 0; n < 4; n++)
      check($sformatf("out_data%0d", n), 32'(bus.out_data[n*W +: W]), 32'(m_data[n]));
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    // words leaving this cycle must come out in the order they were sent
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        if (m_valid[n] && ordy[n] && exp_q[n].size() != 0)
          check($sformatf("deliver%0d", n), 32'(bus.out_data[n*W +: W]), 32'(exp_q[n].pop_front()));
      end
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (acc && t == n) begin
          m_valid[n] = 1'b1;
          m_data[n]  = d;
          exp_q[n].push_back(d);
        end else if (m_valid[n] && ordy[n]) begin
          m_valid[n] = 1'b0;
        end
      end
      if (acc) begin
        m_cnt = m_cnt + 1'b1;
        m_ptr = (m_ptr + 1) % 4;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.din       = '0;
    bus.E0        = 1'b0;
    bus.E1        = 1'b0;
    bus.out_ready = 4'd0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset held with in_valid high: nothing accepted, in_ready low
    cycle(1'b0, 1'b1, 4'hA, 2'd1, 4'hF);
    cycle(1'b0, 1'b1, 4'h5, 2'd2, 4'hF);

    // addressed steer to channels 0..3 with all consumers ready
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 4'h1, 2'(k), 4'hF);
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 4'hF);
    #1 check("steer_cnt", 32'(xfer_cnt), 32'd4);

    // backpressure on channel 2: first word held, second stalls, then both drain in order
    cycle(1'b1, 1'b1, 4'h3, 2'd2, 4'h0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 4'h9, 2'd2, 4'h0);
    cycle(1'b1, 1'b1, 4'h9, 2'd2, 4'b0100);
    cycle(1'b1, 1'b0, 4'h0, 2'd2, 4'b0100);
    cycle(1'b1, 1'b0, 4'h0, 2'd2, 4'h0);

    // same-cycle drain and load on channel 1
    cycle(1'b1, 1'b1, 4'hC, 2'd1, 4'h0);
    cycle(1'b1, 1'b1, 4'hD, 2'd1, 4'b0010);
    cycle(1'b1, 1'b0, 4'h0, 2'd1, 4'h0);
    cycle(1'b1, 1'b0, 4'h0, 2'd1, 4'hF);

    // counter wrap after 256 accepts from a fresh reset
    cycle(1'b0, 1'b0, 4'h0, 2'd0, 4'hF);
    for (int k = 0; k < 256; k++)
      cycle(1'b1, 1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'hF);
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 4'hF);
    #1 check("wrap_cnt", 32'(xfer_cnt), 32'd0);

`ifdef DISTRIBUTOR_ROUND_ROBIN_EN
    // round robin with select fixed at 0: channels 0,1,2,3,0
    cycle(1'b0, 1'b0, 4'h0, 2'd0, 4'hF);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 4'(k + 1), 2'd0, 4'hF);
      #1 check("rr_chan", {28'd0, bus.out_valid}, 32'(1 << (k % 4)));
    end
    // channel 1 never ready: after filling it the pointer parks at 1 and input stalls
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 4'h7, 2'd0, 4'b1101);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 4'h8, 2'd0, 4'b1101);
      #1 check("rr_stall", {31'd0, bus.in_ready}, 32'd0);
    end
    cycle(1'b1, 1'b1, 4'h8, 2'd0, 4'hF);
    cycle(1'b1, 1'b0, 4'h0, 2'd0, 4'hF);
`endif

    // randomized traffic with occasional mid-run reset
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 60) != 0), 1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
